// File: rtl/div_iterative_pkg.sv
// Shared definitions for the iterative divider: FSM encoding, div_op bit
// positions, latency and counter sizing.
package div_iterative_pkg;

  localparam int DIV_W_DEF   = 32;
  localparam int DIV_LATENCY = DIV_W_DEF + 1;
  localparam int CNT_W       = 6;

  // Bit positions inside div_op
  localparam int OP_UNSIGNED = 1;
  localparam int OP_REM      = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_iterative_step.sv
// One radix-2 restoring division step: shift the remainder/quotient register
// left, trial-subtract the divisor, keep the difference when it fits.
module div_step #(
  parameter int W = 32
) (
  input  logic [2*W:0] rq,
  input  logic [W-1:0] divisor,
  output logic [2*W:0] rq_next
);

  logic [W+1:0] rem_sh;
  logic [W+1:0] trial;
  logic         fits;

  // NOTE: every output of a combinational block is assigned on every path,
  // so no latch can be inferred.
  always_comb begin
    rem_sh  = rq[2*W:W-1];
    trial   = rem_sh - {2'b00, divisor};
    fits    = ~trial[W+1];
    rq_next = {(fits ? trial[W:0] : rem_sh[W:0]), rq[W-2:0], fits};
  end

endmodule

// File: rtl/div_iterative.sv
// Multi-cycle signed/unsigned integer divider: one restoring step per cycle
// on operand magnitudes, sign fix-up applied when the last step completes.
module div_iterative
  import div_iterative_pkg::*;
#(
  parameter int DIV_W = 32
) (
  input  logic             div_clk,
  input  logic             reset,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic [1:0]       div_op,
  input  logic [DIV_W-1:0] X,
  input  logic [DIV_W-1:0] Y,
  input  logic             div_cancel,
  output logic             div_done,
  output logic [DIV_W-1:0] result
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_W - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*DIV_W:0]   rq;
  logic [2*DIV_W:0]   rq_next;
  logic [DIV_W-1:0]   divisor;
  logic               op_rem;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;

  logic               is_signed;
  logic               x_neg;
  logic               y_neg;
  logic [DIV_W-1:0]   abs_x;
  logic [DIV_W-1:0]   abs_y;
  logic [DIV_W-1:0]   q_mag;
  logic [DIV_W-1:0]   r_mag;
  logic [DIV_W-1:0]   quo;
  logic [DIV_W-1:0]   rem;
  logic [DIV_W-1:0]   final_res;

  always_comb begin
    is_signed = ~div_op[OP_UNSIGNED];
    x_neg     = is_signed & X[DIV_W-1];
    y_neg     = is_signed & Y[DIV_W-1];
    abs_x     = x_neg ? -X : X;
    abs_y     = y_neg ? -Y : Y;
  end

  div_step #(.W(DIV_W)) u_step (
    .rq      (rq),
    .divisor (divisor),
    .rq_next (rq_next)
  );

  // Divide-by-zero leaves an all-ones magnitude quotient that must not be
  // sign-flipped; the remainder magnitude re-signed gives X back unchanged.
  always_comb begin
    q_mag     = rq_next[DIV_W-1:0];
    r_mag     = rq_next[2*DIV_W-1:DIV_W];
    quo       = div_zero ? '1 : (neg_q ? -q_mag : q_mag);
    rem       = neg_r ? -r_mag : r_mag;
    final_res = op_rem ? rem : quo;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge div_clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rq       <= '0;
      divisor  <= '0;
      op_rem   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (div_valid && !div_cancel) begin
            state    <= S_CALC;
            cnt      <= '0;
            rq       <= {{(DIV_W+1){1'b0}}, abs_x};
            divisor  <= abs_y;
            op_rem   <= div_op[OP_REM];
            neg_q    <= x_neg ^ y_neg;
            neg_r    <= x_neg;
            div_zero <= (Y == '0);
          end
        end
        S_CALC: begin
          if (div_cancel) begin
            state <= S_IDLE;
          end else begin
            rq  <= rq_next;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
              state  <= S_DONE;
              result <= final_res;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign div_ready = (state == S_IDLE);
  // A flush arriving in the DONE cycle still suppresses the pulse.
  assign div_done  = (state == S_DONE) && !div_cancel;

endmodule

// File: tb/tb_div_iterative.sv
// Directed bench for div_iterative: scoreboard of expected results pushed at
// accept, popped and compared when div_done fires.
module tb_div_iterative;
  import div_iterative_pkg::*;

  logic        div_clk = 1'b0;
  logic        reset;
  logic        div_valid;
  logic        div_ready;
  logic [1:0]  div_op;
  logic [31:0] X;
  logic [31:0] Y;
  logic        div_cancel;
  logic        div_done;
  logic [31:0] result;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;
  int          cycle = 0;
  int          done_cycle = 0;

  always #5 div_clk = ~div_clk;
  always @(posedge div_clk) cycle++;

  div_iterative #(.DIV_W(32)) dut (
    .div_clk    (div_clk),
    .reset      (reset),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .div_op     (div_op),
    .X          (X),
    .Y          (Y),
    .div_cancel (div_cancel),
    .div_done   (div_done),
    .result     (result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: truncating division, remainder takes the sign of X.
  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic [1:0] op);
    logic [31:0] q;
    logic [31:0] r;
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (op[1]) begin
      q = x / y;
      r = x % y;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
    end
    return op[0] ? r : q;
  endfunction

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [1:0] op);
    @(negedge div_clk);
    check("ready_at_issue", {31'b0, div_ready}, 32'd1);
    div_valid = 1'b1;
    X         = x;
    Y         = y;
    div_op    = op;
    exp_q.push_back(model(x, y, op));
    @(negedge div_clk);
    div_valid = 1'b0;
    X         = $urandom;
    Y         = $urandom;
    div_op    = 2'($urandom);
  endtask

  // Called on the first CALC-cycle negedge; counts cycles since accept.
  task automatic await_done(input string tag);
    int k = 1;
    while (!div_done && k < 100) begin
      @(negedge div_clk);
      k++;
    end
    done_cycle = cycle;
    check({tag, "_latency"}, 32'(k), 32'(DIV_LATENCY));
    check({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() != 0) begin
      last_exp = exp_q.pop_front();
      check(tag, result, last_exp);
    end
  endtask

  task automatic watch_no_done(input string tag, input int n);
    int seen = 0;
    repeat (n) begin
      @(negedge div_clk);
      if (div_done) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    int c0;
    logic [31:0] rx;
    logic [31:0] ry;
    reset      = 1'b1;
    div_valid  = 1'b0;
    div_cancel = 1'b0;
    div_op     = 2'b00;
    X          = '0;
    Y          = '0;
    repeat (3) @(negedge div_clk);
    check("rst_ready", {31'b0, div_ready}, 32'd1);
    check("rst_done", {31'b0, div_done}, 32'd0);
    check("rst_result", result, 32'd0);
    reset = 1'b0;

    issue(32'd100, 32'd7, 2'b10);
    await_done("u_quo");
    @(negedge div_clk);
    check("done_one_cycle", {31'b0, div_done}, 32'd0);
    check("result_hold", result, last_exp);
    issue(32'd100, 32'd7, 2'b11);
    await_done("u_rem");

    issue(32'hFFFF_FFF9, 32'd2, 2'b00);
    await_done("s_quo_neg");
    issue(32'hFFFF_FFF9, 32'd2, 2'b01);
    await_done("s_rem_neg");

    issue(32'h8000_0000, 32'hFFFF_FFFF, 2'b00);
    await_done("ovf_quo");
    issue(32'h8000_0000, 32'hFFFF_FFFF, 2'b01);
    await_done("ovf_rem");

    for (int op = 0; op < 4; op++) begin
      issue(32'h1234_5678, 32'd0, 2'(op));
      await_done("div0");
    end

    for (int i = 0; i < 4; i++) begin
      rx = $urandom;
      ry = (i == 0) ? 32'(-3) : $urandom_range(1, 32'h0001_0000);
      issue(rx, ry, 2'(i));
      await_done("rand");
    end

    // Back-to-back: second request presented in the cycle after div_done.
    issue(32'd1000, 32'd10, 2'b10);
    await_done("b2b_a");
    c0 = done_cycle;
    issue(32'hFFFF_FC18, 32'd7, 2'b01);
    await_done("b2b_b");
    check("b2b_spacing", 32'(done_cycle - c0), 32'd34);

    // Flush at CALC cycle 10.
    issue(32'd5000, 32'd3, 2'b10);
    repeat (9) @(negedge div_clk);
    div_cancel = 1'b1;
    @(negedge div_clk);
    div_cancel = 1'b0;
    check("cancel_ready", {31'b0, div_ready}, 32'd1);
    check("cancel_done", {31'b0, div_done}, 32'd0);
    void'(exp_q.pop_front());
    watch_no_done("cancel_no_done", 40);
    issue(32'd5000, 32'd3, 2'b11);
    await_done("after_cancel");

    // Cancel beats valid in IDLE.
    @(negedge div_clk);
    div_valid  = 1'b1;
    div_cancel = 1'b1;
    X          = 32'd9;
    Y          = 32'd3;
    @(negedge div_clk);
    div_valid  = 1'b0;
    div_cancel = 1'b0;
    check("cancel_wins_ready", {31'b0, div_ready}, 32'd1);
    watch_no_done("cancel_wins_no_done", 40);

    // Reset mid-CALC.
    issue(32'd777, 32'd5, 2'b10);
    repeat (5) @(negedge div_clk);
    reset = 1'b1;
    @(negedge div_clk);
    reset = 1'b0;
    check("midrst_ready", {31'b0, div_ready}, 32'd1);
    check("midrst_result", result, 32'd0);
    void'(exp_q.pop_front());
    watch_no_done("midrst_no_done", 40);
    issue(32'd777, 32'd5, 2'b11);
    await_done("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
